// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - Opcodes, FSM states, flag record and counter sizing for alu_seq
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DIV  = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_PASS = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_t;

  typedef struct packed {
    logic zero;
    logic acarry;
    logic lcarry;
    logic sign;
    logic overflow;
  } flags_t;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - Operand handshake, result/flag and data-bus signals of alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       operation;
  logic [WIDTH-1:0] lhs_in;
  logic [WIDTH-1:0] rhs_in;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             assert_bus;
  logic [WIDTH-1:0] bus_out;
  logic             bus_en;
  logic             flag_zero;
  logic             flag_acarry;
  logic             flag_lcarry;
  logic             flag_sign;
  logic             flag_overflow;

  modport master (
    output op_valid, operation, lhs_in, rhs_in, assert_bus,
    input  op_ready, result_valid, result, result_hi, bus_out, bus_en,
    input  flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow
  );

  modport slave (
    input  op_valid, operation, lhs_in, rhs_in, assert_bus,
    output op_ready, result_valid, result, result_hi, bus_out, bus_en,
    output flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow
  );

endinterface

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - Iterative shift-add multiplier; restoring divider when ALU_DIV_EN is defined
// lo/hi present the result of the step taken at the coming edge, so done marks the final step.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = cnt_bits(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  // Multiplier sits in acc_lo and is consumed LSB first while the product shifts in from the top.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  logic             div_mode;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // A zero divisor always fits, yielding an all-ones quotient and the dividend as remainder.
  assign shifted = {acc_hi, acc_lo[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, opnd});
  assign diff    = shifted[WIDTH-1:0] - opnd;
  assign hi      = div_mode ? (fits ? diff : shifted[WIDTH-1:0]) : mul_hi;
  assign lo      = div_mode ? {acc_lo[WIDTH-2:0], fits} : mul_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_mode <= 1'b0;
    end else if (start) begin
      div_mode <= is_div;
    end
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
  assign hi            = mul_hi;
  assign lo            = mul_lo;
`endif

  assign done = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else if (start) begin
      cnt    <= CW'(WIDTH);
      acc_hi <= '0;
      acc_lo <= lhs;
      opnd   <= rhs;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      acc_hi <= hi;
      acc_lo <= lo;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - Multi-cycle ALU with registered result/flags and iterative MUL
// Defining ALU_DIV_EN turns opcode D into an iterative unsigned divide.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             is_iter_op;
  logic             is_div_op;
  logic             start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;

  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             res_valid_q;
  flags_t           flags_q;
  flags_t           sc_flags;
  flags_t           it_flags;

  logic [3:0]       op;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH:0]   sum;
  logic             cin;
  logic             sc_wr_res;
  logic             sc_upd_zs;

  assign op            = bus.operation;
  assign lhs           = bus.lhs_in;
  assign rhs           = bus.rhs_in;
  assign bus.op_ready  = (state == ST_IDLE);
  assign accept        = bus.op_valid & bus.op_ready;
  assign is_div_op     = (op == OP_DIV);

`ifdef ALU_DIV_EN
  assign is_iter_op = (op == OP_MUL) || is_div_op;
`else
  assign is_iter_op = (op == OP_MUL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_iter_op) begin
          start    = 1'b1;
          state_nx = ST_ITER;
        end
      end
      ST_ITER: begin
        if (iter_done) begin
          state_nx = ST_IDLE;
        end
      end
    endcase
  end

  alu_seq_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .is_div (is_div_op),
    .lhs    (lhs),
    .rhs    (rhs),
    .done   (iter_done),
    .lo     (iter_lo),
    .hi     (iter_hi)
  );

  // Subtraction is addition of ~rhs; acarry therefore reads as "no borrow".
  always_comb begin
    add_b = rhs;
    cin   = 1'b0;
    case (op)
      OP_ADC:         cin = flags_q.acarry;
      OP_SUB, OP_CMP: begin
        add_b = ~rhs;
        cin   = 1'b1;
      end
      OP_SBC: begin
        add_b = ~rhs;
        cin   = flags_q.acarry;
      end
      default: ;
    endcase
    sum = {1'b0, lhs} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    sc_res    = '0;
    sc_flags  = flags_q;
    sc_wr_res = 1'b1;
    sc_upd_zs = 1'b1;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
        sc_res            = sum[MSB:0];
        sc_flags.acarry   = sum[WIDTH];
        sc_flags.overflow = (lhs[MSB] ^ sum[MSB]) & (add_b[MSB] ^ sum[MSB]);
        sc_wr_res         = (op != OP_CMP);
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_PASS: begin
        sc_flags.acarry   = 1'b0;
        sc_flags.overflow = 1'b0;
        case (op)
          OP_AND:  sc_res = lhs & rhs;
          OP_OR:   sc_res = lhs | rhs;
          OP_XOR:  sc_res = lhs ^ rhs;
          OP_NOT:  sc_res = ~lhs;
          default: sc_res = rhs;
        endcase
      end
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
        sc_flags.overflow = 1'b0;
        case (op)
          OP_SHL: begin
            sc_res          = {lhs[MSB-1:0], 1'b0};
            sc_flags.lcarry = lhs[MSB];
          end
          OP_SHR: begin
            sc_res          = {1'b0, lhs[MSB:1]};
            sc_flags.lcarry = lhs[0];
          end
          OP_ROL: begin
            sc_res          = {lhs[MSB-1:0], flags_q.lcarry};
            sc_flags.lcarry = lhs[MSB];
          end
          default: begin
            sc_res          = {flags_q.lcarry, lhs[MSB:1]};
            sc_flags.lcarry = lhs[0];
          end
        endcase
      end
      default: begin
        // Only opcode D reaches here without the divider: a no-op that still acknowledges.
        sc_wr_res = 1'b0;
        sc_upd_zs = 1'b0;
      end
    endcase
    if (sc_upd_zs) begin
      sc_flags.zero = ~|sc_res;
      sc_flags.sign = sc_res[MSB];
    end
  end

`ifdef ALU_DIV_EN
  logic iter_div;
  logic div_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_div <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      iter_div <= is_div_op;
      div_zero <= ~|rhs;
    end
  end
`endif

  always_comb begin
    it_flags          = flags_q;
    it_flags.zero     = ~|{iter_hi, iter_lo};
    it_flags.acarry   = |iter_hi;
    it_flags.sign     = iter_hi[MSB];
    it_flags.overflow = 1'b0;
`ifdef ALU_DIV_EN
    if (iter_div) begin
      it_flags.zero     = ~|iter_lo;
      it_flags.acarry   = 1'b0;
      it_flags.sign     = iter_lo[MSB];
      it_flags.overflow = div_zero;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      res_hi_q    <= '0;
      flags_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      if (accept && !is_iter_op) begin
        res_valid_q <= 1'b1;
        flags_q     <= sc_flags;
        if (sc_wr_res) begin
          res_q    <= sc_res;
          res_hi_q <= '0;
        end
      end else if (state == ST_ITER && iter_done) begin
        res_valid_q <= 1'b1;
        flags_q     <= it_flags;
        res_q       <= iter_lo;
        res_hi_q    <= iter_hi;
      end
    end
  end

  assign bus.result        = res_q;
  assign bus.result_hi     = res_hi_q;
  assign bus.result_valid  = res_valid_q;
  assign bus.flag_zero     = flags_q.zero;
  assign bus.flag_acarry   = flags_q.acarry;
  assign bus.flag_lcarry   = flags_q.lcarry;
  assign bus.flag_sign     = flags_q.sign;
  assign bus.flag_overflow = flags_q.overflow;
  assign bus.bus_out       = res_q;
  assign bus.bus_en        = ~bus.assert_bus;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - Scoreboard bench for alu_seq; follows ALU_DIV_EN for opcode D expectations
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct packed {
    int         id;
    int         cyc;
    logic [7:0] res;
    logic [7:0] hi;
    logic [4:0] fl;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   nid = 0;
  exp_t sb[$];
  exp_t got_e;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wire [4:0] fl_act = {bus.flag_zero, bus.flag_acarry, bus.flag_lcarry, bus.flag_sign, bus.flag_overflow};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        got_e = sb.pop_front();
        check($sformatf("op%0d_cycle", got_e.id), cyc, got_e.cyc);
        check($sformatf("op%0d_result", got_e.id), bus.result, got_e.res);
        check($sformatf("op%0d_result_hi", got_e.id), bus.result_hi, got_e.hi);
        check($sformatf("op%0d_flags_zalso", got_e.id), fl_act, got_e.fl);
        check($sformatf("op%0d_bus_out", got_e.id), bus.bus_out, got_e.res);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.op_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("op_ready_before_issue", bus.op_ready, 1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic [7:0] h, input logic [4:0] f,
                       input int lat, input bit want);
    exp_t e;
    wait_ready();
    bus.op_valid  = 1'b1;
    bus.operation = op;
    bus.lhs_in    = a;
    bus.rhs_in    = b;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    if (want) begin
      e.id  = nid;
      e.cyc = cyc + lat;
      e.res = r;
      e.hi  = h;
      e.fl  = f;
      sb.push_back(e);
    end
    nid++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.op_valid   = 1'b0;
    bus.operation  = 4'h0;
    bus.lhs_in     = 8'h00;
    bus.rhs_in     = 8'h00;
    bus.assert_bus = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_result", bus.result, 0);
    check("rst_result_hi", bus.result_hi, 0);
    check("rst_flags", fl_act, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_op_ready", bus.op_ready, 1);
    check("bus_en_idle", bus.bus_en, 0);
    rst_n = 1'b1;

    // flags are {zero, acarry, lcarry, sign, overflow}
    issue(OP_ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 5'b11000, 0, 1'b1);
    issue(OP_ADC,  8'h00, 8'h00, 8'h01, 8'h00, 5'b00000, 0, 1'b1);
    bus.assert_bus = 1'b0;
    #1;
    check("bus_en_drive", bus.bus_en, 1);
    issue(OP_SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 5'b01001, 0, 1'b1);
    issue(OP_SUB,  8'h00, 8'h01, 8'hFF, 8'h00, 5'b00010, 0, 1'b1);
    issue(OP_CMP,  8'h05, 8'h05, 8'hFF, 8'h00, 5'b11000, 0, 1'b1);
    issue(OP_ROL,  8'h81, 8'h00, 8'h02, 8'h00, 5'b01100, 0, 1'b1);
    issue(OP_ROR,  8'h02, 8'h00, 8'h81, 8'h00, 5'b01010, 0, 1'b1);
    issue(OP_SHL,  8'h80, 8'h00, 8'h00, 8'h00, 5'b11100, 0, 1'b1);
    issue(OP_SHR,  8'h02, 8'h00, 8'h01, 8'h00, 5'b01000, 0, 1'b1);
    issue(OP_XOR,  8'hA5, 8'hFF, 8'h5A, 8'h00, 5'b00000, 0, 1'b1);
    issue(OP_NOT,  8'h0F, 8'h00, 8'hF0, 8'h00, 5'b00010, 0, 1'b1);
    issue(OP_PASS, 8'h12, 8'h00, 8'h00, 8'h00, 5'b10000, 0, 1'b1);

    issue(OP_MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b01010, 8, 1'b1);
    bus.lhs_in = 8'h00;
    bus.rhs_in = 8'h00;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.op_ready) break;
      n++;
      if (n == 3) begin
        bus.op_valid  = 1'b1;
        bus.operation = OP_ADD;
        bus.lhs_in    = 8'h11;
        bus.rhs_in    = 8'h22;
      end
      if (n == 4) bus.op_valid = 1'b0;
    end
    check("mul_ready_low_cycles", n, 8);

    issue(OP_MUL,  8'h10, 8'h10, 8'h00, 8'h00, 5'b00000, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_result", bus.result, 0);
    check("abort_result_hi", bus.result_hi, 0);
    check("abort_flags", fl_act, 0);
    check("abort_op_ready", bus.op_ready, 1);
    check("abort_result_valid", bus.result_valid, 0);
    check("abort_bus_out", bus.bus_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD,  8'h03, 8'h04, 8'h07, 8'h00, 5'b00000, 0, 1'b1);

`ifdef ALU_DIV_EN
    issue(OP_DIV,  8'h64, 8'h07, 8'h0E, 8'h02, 5'b00000, 8, 1'b1);
    issue(OP_DIV,  8'h5A, 8'h00, 8'hFF, 8'h5A, 5'b00011, 8, 1'b1);
`else
    issue(OP_DIV,  8'h33, 8'h44, 8'h07, 8'h00, 5'b00000, 0, 1'b1);
`endif

    repeat (12) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
